// File: rtl/pillar_pkg.sv
// pillar_pkg: shared types and constants for the pillar scheduler.
// Holds the FSM state enum and the LFSR seed/tap constants.
package pillar_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    OVER
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Taps 16,14,13,11 of a right-shifting register sit on bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/pillar_lfsr.sv
// pillar_lfsr: free-running 16-bit Fibonacci LFSR.
// Advances every clock; reset loads the package seed.
module pillar_lfsr
  import pillar_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  // Shift right, feedback from the tap XOR into the MSB.
  always_ff @(posedge clk) begin
    if (reset) q <= LFSR_SEED;
    else       q <= {^(q & LFSR_TAPS), q[15:1]};
  end

endmodule

// File: rtl/pillar_scheduler.sv
// pillar_scheduler: play FSM, step divider and pillar spawner.
// Optional auto speed-up under `PILLAR_SCHED_SPEEDUP_EN.
module pillar_scheduler
  import pillar_pkg::*;
#(
  parameter int GAP_W       = 4,
  parameter int SPACING     = 6,
  parameter int BASE_PERIOD = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        hold,
  input  logic        collide,
  input  logic [1:0]  speed,
  output logic [15:0] pattern_out,
  output logic        step,
  output logic        spawned,
  output logic        running,
  output logic [7:0]  score
);

  localparam logic [15:0] GAP_ONES =
    16'((32'd1 << GAP_W) - 32'd1);
  localparam int R_MAX = 16 - GAP_W;

  state_t      state, state_n;
  logic        accept;
  logic        advance;
  logic        tick;
  logic        spawn_now;
  logic [6:0]  div;
  logic [6:0]  period_m1;
  logic [3:0]  spawn_cnt;
  logic [1:0]  eff_speed;
  logic [3:0]  offset;
  logic [15:0] gap_pat;
  logic [15:0] lfsr_q;
  logic        lfsr_unused;

  pillar_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  assign lfsr_unused = ^lfsr_q[15:4];

`ifdef PILLAR_SCHED_SPEEDUP_EN
  logic [1:0] auto_lvl;
  logic [2:0] spawn8;

  // Auto level climbs once per eight spawns, capped at 3.
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      auto_lvl <= 2'd0;
      spawn8   <= 3'd0;
    end else if (spawn_now) begin
      spawn8 <= spawn8 + 3'd1;
      if (spawn8 == 3'd7 && auto_lvl != 2'd3)
        auto_lvl <= auto_lvl + 2'd1;
    end
  end

  assign eff_speed =
    (auto_lvl > speed) ? auto_lvl : speed;
`else
  assign eff_speed = speed;
`endif

  assign period_m1 =
    7'(BASE_PERIOD * (4 - int'(eff_speed)) - 1);

  // Fold gap offsets that would run off the top row.
  always_comb begin
    offset = lfsr_q[3:0];
    if (int'(lfsr_q[3:0]) > R_MAX)
      offset = 4'(int'(lfsr_q[3:0]) - GAP_W);
  end

  assign gap_pat = ~(GAP_ONES << offset);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state; collide outranks hold while playing.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    unique case (1'b1)
      (state == IDLE || state == OVER): begin
        if (start) begin
          state_n = RUN;
          accept  = 1'b1;
        end
      end
      (state == RUN): begin
        if (collide)   state_n = OVER;
        else if (hold) state_n = PAUSE;
      end
      (state == PAUSE): begin
        if (collide)    state_n = OVER;
        else if (!hold) state_n = RUN;
      end
      default: state_n = IDLE;
    endcase
  end

  assign advance   = (state == RUN) && (state_n == RUN);
  assign tick      = advance && (div == 7'd0);
  assign spawn_now = tick && (spawn_cnt == 4'd0);
  assign running   = (state == RUN);

  // Divider, spawn counter, pattern and score.
  always_ff @(posedge clk) begin
    if (reset) begin
      div         <= 7'd0;
      spawn_cnt   <= 4'd0;
      pattern_out <= 16'h0000;
      step        <= 1'b0;
      spawned     <= 1'b0;
      score       <= 8'd0;
    end else begin
      step    <= tick;
      spawned <= spawn_now;
      if (accept) begin
        div         <= period_m1;
        spawn_cnt   <= 4'd0;
        pattern_out <= 16'h0000;
        score       <= 8'd0;
      end else if (tick) begin
        div <= period_m1;
        spawn_cnt <= (spawn_cnt == 4'(SPACING - 1))
                   ? 4'd0 : spawn_cnt + 4'd1;
        pattern_out <= spawn_now ? gap_pat : 16'h0000;
        if (spawn_now && score != 8'hFF)
          score <= score + 8'd1;
      end else if (advance) begin
        div <= div - 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_pillar_scheduler.sv
// tb_pillar_scheduler: directed checks for pillar_scheduler.
// Default parameters; speed-up leg under PILLAR_SCHED_SPEEDUP_EN.
module tb_pillar_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        hold;
  logic        collide;
  logic [1:0]  speed;
  logic [15:0] pattern_out;
  logic        step;
  logic        spawned;
  logic        running;
  logic [7:0]  score;

  int checks = 0;
  int errors = 0;
  int exp_score = 0;
  logic [15:0] m, m_prev, exp_last;

  pillar_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .hold        (hold),
    .collide     (collide),
    .speed       (speed),
    .pattern_out (pattern_out),
    .step        (step),
    .spawned     (spawned),
    .running     (running),
    .score       (score)
  );

  always #5 clk = ~clk;

  // Reference LFSR; m_prev is the value seen before the last edge.
  always_ff @(posedge clk) begin
    m_prev <= m;
    if (reset) m <= 16'hACE1;
    else       m <= {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Gap of four zeros at the folded offset.
  function automatic logic [15:0] exp_pat(input logic [15:0] l);
    int r;
    r = int'(l[3:0]);
    if (r > 12) r = r - 4;
    return ~(16'h000F << r);
  endfunction

  task automatic step_chk(input string tag,
                          input int exp_n,
                          input bit sp);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!step && n < 100);
    check({tag, "_gap"}, n, exp_n);
    if (sp) exp_score++;
    check({tag, "_spawned"}, spawned, sp);
    check({tag, "_pat"}, pattern_out,
          sp ? exp_pat(m_prev) : 16'h0000);
    check({tag, "_score"}, score, exp_score);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; hold = 1'b0;
    collide = 1'b0; speed = 2'd3;
    repeat (5) cyc();
    check("rst_step", step, 0);
    check("rst_spawned", spawned, 0);
    check("rst_running", running, 0);
    check("rst_score", score, 0);
    check("rst_pat", pattern_out, 0);

    reset = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("start_run", running, 1);
    check("start_pat", pattern_out, 0);
    check("start_score", score, 0);
    exp_score = 0;
    step_chk("first", 4, 1'b1);
    for (int k = 2; k <= 13; k++)
      step_chk("run", 4, (k == 7) || (k == 13));

    speed = 2'd0;
    step_chk("spd_old", 4, 1'b0);
    step_chk("spd0", 16, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("spd_mid", step, 0);
    end
    speed = 2'd2;
    step_chk("spd_keep", 11, 1'b0);
    step_chk("spd2", 8, 1'b0);

    repeat (3) cyc();
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("hold_step", step, 0);
      check("hold_run", running, 0);
    end
    hold = 1'b0;
    step_chk("resume", 6, 1'b0);
    step_chk("sp19", 8, 1'b1);
    exp_last = exp_pat(m_prev);

    repeat (2) cyc();
    hold = 1'b1;
    collide = 1'b1;
    cyc();
    check("over_run", running, 0);
    check("over_step", step, 0);
    check("over_pat", pattern_out, exp_last);
    repeat (3) cyc();
    check("over_hold_pat", pattern_out, exp_last);
    check("over_stay", running, 0);
    check("over_score", score, 4);
    hold = 1'b0;
    collide = 1'b0;

    start = 1'b1;
    cyc();
    start = 1'b0;
    check("restart_run", running, 1);
    check("restart_score", score, 0);
    check("restart_pat", pattern_out, 0);
    exp_score = 0;
    step_chk("restart", 8, 1'b1);

    reset = 1'b1;
    cyc();
    check("mid_rst_run", running, 0);
    check("mid_rst_step", step, 0);
    check("mid_rst_spawned", spawned, 0);
    check("mid_rst_score", score, 0);
    check("mid_rst_pat", pattern_out, 0);
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
    check("idle_run", running, 0);

    collide = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("idle_col_start", running, 1);
    cyc();
    check("run_collide", running, 0);
    collide = 1'b0;

`ifdef PILLAR_SCHED_SPEEDUP_EN
    speed = 2'd0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    exp_score = 0;
    for (int i = 1; i <= 43; i++)
      step_chk("auto", 16, (i % 6) == 1);
    step_chk("auto16", 16, 1'b0);
    step_chk("auto12", 12, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
